// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase tracker slice.
// FSM state encodings and sticky error codes.
package johnson_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SKIP    = 2'b10;

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational decode of a Johnson code into legality,
// binary phase index and one-hot phase.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int BITS = 4,
    localparam int PH_N = 2 * BITS,
    localparam int PH_W = $clog2(PH_N)
) (
    input  logic [BITS-1:0] jc_q,
    output logic            legal,
    output logic [PH_W-1:0] phase,
    output logic [PH_N-1:0] onehot
);

    int edges;
    int ones;

    always_comb begin
        edges = 0;
        ones  = 0;
        for (int i = 0; i < BITS - 1; i++) begin
            if (jc_q[i] != jc_q[i+1]) begin
                edges = edges + 1;
            end
        end
        for (int i = 0; i < BITS; i++) begin
            ones = ones + int'(jc_q[i]);
        end
    end

    // A legal code has at most one 0/1 boundary across the word
    assign legal = (edges <= 1);

    always_comb begin
        phase = '0;
        if (jc_q == '0) begin
            phase = '0;
        end else if (jc_q[BITS-1]) begin
            phase = PH_W'(ones);
        end else begin
            phase = PH_W'(PH_N - ones);
        end
    end

    assign onehot = PH_N'(1) << phase;

endmodule

// File: rtl/johnson_phase_tracker.sv
// Tracks a Johnson counter: decodes phase, checks +1 stepping,
// counts revolutions and latches the first fault seen.
module johnson_phase_tracker
    import johnson_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int CNT_W = 8,
    localparam int PH_N = 2 * BITS,
    localparam int PH_W = $clog2(PH_N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic [BITS-1:0]  jc_q,
    output logic [PH_W-1:0]  phase,
    output logic [PH_N-1:0]  phase_onehot,
    output logic             phase_valid,
    output logic             wrap,
    output logic [CNT_W-1:0] rev_count,
    output logic [1:0]       err_code
);

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(PH_N - 1);

    logic            dec_legal;
    logic [PH_W-1:0] dec_phase;
    logic [PH_N-1:0] dec_onehot;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PH_N-1:0]  onehot_q, onehot_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] rev_q, rev_d;
    logic [1:0]       err_q, err_d;
    logic [PH_W-1:0]  step_phase;

    johnson_code_decode #(
        .BITS (BITS)
    ) u_decode (
        .jc_q   (jc_q),
        .legal  (dec_legal),
        .phase  (dec_phase),
        .onehot (dec_onehot)
    );

    // Expected next phase; modulo handled explicitly for non-pow2 BITS
    assign step_phase = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        onehot_d = onehot_q;
        wrap_d   = 1'b0;
        rev_d    = rev_q;
        err_d    = err_q;
        if (clear) begin
            state_d = ST_ACQUIRE;
            rev_d   = '0;
            err_d   = ERR_NONE;
        end else if (en) begin
            unique case (state_q)
                ST_ACQUIRE: begin
                    if (dec_legal) begin
                        state_d  = ST_TRACK;
                        phase_d  = dec_phase;
                        onehot_d = dec_onehot;
                    end else begin
                        state_d = ST_FAULT;
                        err_d   = ERR_ILLEGAL;
                    end
                end
                ST_TRACK: begin
                    if (!dec_legal) begin
                        state_d = ST_FAULT;
                        err_d   = ERR_ILLEGAL;
                    end else if (dec_phase != step_phase) begin
                        state_d = ST_FAULT;
                        err_d   = ERR_SKIP;
                    end else begin
                        phase_d  = dec_phase;
                        onehot_d = dec_onehot;
                        if (phase_q == LAST_PH) begin
                            wrap_d = 1'b1;
                            rev_d  = rev_q + CNT_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (dec_legal) begin
                        phase_d  = dec_phase;
                        onehot_d = dec_onehot;
                    end
                end
                default: begin
                    state_d = ST_ACQUIRE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ACQUIRE;
            phase_q  <= '0;
            onehot_q <= '0;
            wrap_q   <= 1'b0;
            rev_q    <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            onehot_q <= onehot_d;
            wrap_q   <= wrap_d;
            rev_q    <= rev_d;
            err_q    <= err_d;
        end
    end

    assign phase        = phase_q;
    assign phase_onehot = onehot_q;
    assign phase_valid  = (state_q == ST_TRACK);
    assign wrap         = wrap_q;
    assign rev_count    = rev_q;
    assign err_code     = err_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Scoreboard bench for johnson_phase_tracker (BITS=4, CNT_W=8)
// with a behavioural Johnson counter as the stimulus source.
module tb_johnson_phase_tracker;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       en;
    logic [3:0] jc_q;
    logic [2:0] phase;
    logic [7:0] phase_onehot;
    logic       phase_valid;
    logic       wrap;
    logic [7:0] rev_count;
    logic [1:0] err_code;

    johnson_phase_tracker #(
        .BITS  (4),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .en           (en),
        .jc_q         (jc_q),
        .phase        (phase),
        .phase_onehot (phase_onehot),
        .phase_valid  (phase_valid),
        .wrap         (wrap),
        .rev_count    (rev_count),
        .err_code     (err_code)
    );

    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] oh;
        logic       vld;
        logic       wr;
        logic [7:0] rev;
        logic [1:0] err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [3:0] jc_tab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                               4'b1111, 4'b0111, 4'b0011, 4'b0001};
    int k = 0;

    // Reference model: 0 ACQUIRE, 1 TRACK, 2 FAULT
    int         m_st;
    int         m_ph;
    int         m_oh;
    int         m_rev;
    logic [1:0] m_err;
    logic       m_wr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_st  = 0;
        m_ph  = 0;
        m_oh  = 0;
        m_rev = 0;
        m_err = 2'b00;
        m_wr  = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic c, input logic e, input logic [3:0] code);
        bit lg;
        int p;
        lg = 0;
        p  = 0;
        for (int i = 0; i < 8; i++) begin
            if (jc_tab[i] == code) begin
                lg = 1;
                p  = i;
            end
        end
        m_wr = 1'b0;
        if (c) begin
            m_st  = 0;
            m_rev = 0;
            m_err = 2'b00;
        end else if (e) begin
            if (m_st == 0) begin
                if (lg) begin
                    m_st = 1;
                    m_ph = p;
                    m_oh = 1 << p;
                end else begin
                    m_st  = 2;
                    m_err = 2'b01;
                end
            end else if (m_st == 1) begin
                if (!lg) begin
                    m_st  = 2;
                    m_err = 2'b01;
                end else if (p != (m_ph + 1) % 8) begin
                    m_st  = 2;
                    m_err = 2'b10;
                end else begin
                    if (m_ph == 7) begin
                        m_wr  = 1'b1;
                        m_rev = (m_rev + 1) % 256;
                    end
                    m_ph = p;
                    m_oh = 1 << p;
                end
            end else if (lg) begin
                m_ph = p;
                m_oh = 1 << p;
            end
        end
    endtask

    task automatic do_cycle(input logic c, input logic e, input logic [3:0] code);
        exp_t x;
        @(negedge clk);
        clear = c;
        en    = e;
        jc_q  = code;
        model_step(c, e, code);
        x.ph  = 3'(m_ph);
        x.oh  = 8'(m_oh);
        x.vld = (m_st == 1);
        x.wr  = m_wr;
        x.rev = 8'(m_rev);
        x.err = m_err;
        sb.push_back(x);
    endtask

    // Live counter: advances every cycle whether or not en is high
    task automatic cnt_cycle(input logic c, input logic e);
        do_cycle(c, e, jc_tab[k]);
        k = (k + 1) % 8;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t x;
        exp_t a;
        #1;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            a = {phase, phase_onehot, phase_valid, wrap, rev_count, err_code};
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL sb t=%0t ph %0d/%0d oh %h/%h v %b/%b w %b/%b rev %0d/%0d err %b/%b",
                         $time, a.ph, x.ph, a.oh, x.oh, a.vld, x.vld, a.wr, x.wr,
                         a.rev, x.rev, a.err, x.err);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        clear   = 1'b0;
        en      = 1'b0;
        jc_q    = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({phase, phase_onehot, phase_valid, wrap, rev_count, err_code} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {phase, phase_onehot, phase_valid, wrap, rev_count, err_code});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_revolution();
        k = 0;
        repeat (9) cnt_cycle(1'b0, 1'b1);
        settle();
        checks++;
        if (rev_count !== 8'd1 || phase !== 3'd0 || phase_valid !== 1'b1) begin
            errors++;
            $display("FAIL one_rev rev %0d ph %0d v %b want 1 0 1",
                     rev_count, phase, phase_valid);
        end
    endtask

    task automatic test_illegal();
        repeat (2) cnt_cycle(1'b0, 1'b1);
        do_cycle(1'b0, 1'b1, 4'b1010);
        k = (k + 1) % 8;
        settle();
        checks++;
        if (err_code !== 2'b01 || phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal err %b v %b want 01 0", err_code, phase_valid);
        end
        repeat (5) cnt_cycle(1'b0, 1'b1);
        settle();
        checks++;
        if (err_code !== 2'b01) begin
            errors++;
            $display("FAIL illegal_sticky err %b want 01", err_code);
        end
    endtask

    task automatic test_skip();
        do_cycle(1'b1, 1'b0, 4'b0000);
        k = 0;
        repeat (9) cnt_cycle(1'b0, 1'b1);
        do_cycle(1'b0, 1'b1, 4'b1000);
        do_cycle(1'b0, 1'b1, 4'b1110);
        settle();
        checks++;
        if (err_code !== 2'b10 || rev_count !== 8'd1 || phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL skip err %b rev %0d v %b want 10 1 0",
                     err_code, rev_count, phase_valid);
        end
        do_cycle(1'b1, 1'b1, 4'b1111);
        settle();
        checks++;
        if (err_code !== 2'b00 || rev_count !== 8'd0 || phase !== 3'd1 ||
            phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_en err %b rev %0d ph %0d v %b want 00 0 1 0",
                     err_code, rev_count, phase, phase_valid);
        end
        do_cycle(1'b0, 1'b1, 4'b0011);
        do_cycle(1'b0, 1'b1, 4'b0001);
        settle();
        checks++;
        if (err_code !== 2'b00 || phase !== 3'd7 || phase_valid !== 1'b1) begin
            errors++;
            $display("FAIL reacq err %b ph %0d v %b want 00 7 1",
                     err_code, phase, phase_valid);
        end
    endtask

    task automatic test_en_toggle();
        do_cycle(1'b1, 1'b0, 4'b0000);
        k = 3;
        for (int i = 0; i < 8; i++) begin
            cnt_cycle(1'b0, (i % 2) == 0);
        end
        settle();
        checks++;
        if (err_code !== 2'b10) begin
            errors++;
            $display("FAIL en_toggle err %b want 10", err_code);
        end
    endtask

    task automatic test_rev_wrap();
        do_cycle(1'b1, 1'b0, 4'b0000);
        k = 0;
        repeat (1 + 256 * 8) cnt_cycle(1'b0, 1'b1);
        settle();
        checks++;
        if (rev_count !== 8'd0 || err_code !== 2'b00 || phase_valid !== 1'b1) begin
            errors++;
            $display("FAIL rev_wrap rev %0d err %b v %b want 0 00 1",
                     rev_count, err_code, phase_valid);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) cnt_cycle(1'b0, 1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({phase, phase_onehot, phase_valid, wrap, rev_count, err_code} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0",
                     {phase, phase_onehot, phase_valid, wrap, rev_count, err_code});
        end
        model_reset();
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        k = 5;
        repeat (4) cnt_cycle(1'b0, 1'b1);
        settle();
        checks++;
        if (err_code !== 2'b00 || phase_valid !== 1'b1 || phase !== 3'd0) begin
            errors++;
            $display("FAIL async_reacq err %b v %b ph %0d want 00 1 0",
                     err_code, phase_valid, phase);
        end
    endtask

    initial begin
        test_reset();
        test_revolution();
        test_illegal();
        test_skip();
        test_en_toggle();
        test_rev_wrap();
        test_async_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
